cordic_mul_arbiter: RTL and testbench
=====================================

# cordic_mul_arbiter

Round-robin arbiter and sequencer that shares one CORDIC multiplier instance among `NUM_REQ` requesters. It accepts 8-bit signed operand pairs over per-requester valid/ready handshakes and drives the multiplier's level-held `start`/`done` protocol. It returns each 16-bit result on a single tagged response channel and recovers from a hung multiplier with a watchdog. It sits between the approximate-multiplier datapath and the client blocks that issue multiply jobs.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: width of the requester index, clog2(`NUM_REQ`).
- `TIMEOUT`, default 24: maximum number of BUSY cycles allowed without `mul_done`.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `req_valid`, input, `NUM_REQ`: per-requester job valid.
- `req_x`, input, 8*`NUM_REQ`: signed x operands; requester i uses bits [8i+7:8i].
- `req_z`, input, 8*`NUM_REQ`: signed z operands, packed the same way.
- `req_ready`, output, `NUM_REQ`: one-hot grant; a job is accepted when `req_valid[i]` and `req_ready[i]` are both high at an edge.
- `rsp_valid`, output, 1: response valid.
- `rsp_ready`, input, 1: response consumer ready.
- `rsp_y`, output, 16: result.
- `rsp_id`, output, `ID_W`: index of the originating requester.
- `rsp_err`, output, 1: the response came from a watchdog timeout.
- `mul_start`, output, 1: to the multiplier `start`; registered.
- `mul_x`, output, 8: to the multiplier `x`; registered, stable while `mul_start` is high.
- `mul_z`, output, 8: to the multiplier `z`; registered, stable while `mul_start` is high.
- `mul_done`, input, 1: from the multiplier `done`.
- `mul_y`, input, 16: from the multiplier `y`.
- `busy`, output, 1: state is not IDLE.
- `op_cnt`, output, 16: count of successful completions; wraps at 16'hFFFF to 0.

## Operation
- States: IDLE, BUSY, RESP.
- **IDLE**
  - `req_ready` is combinational, one-hot, and goes to the first requester with `req_valid` high, searching upward from pointer `rr_ptr` with wrap.
  - It is all-zero when no requester is valid, and all-zero in BUSY and RESP.
  - On accept of requester g: latch `req_x[g]` into `mul_x` and `req_z[g]` into `mul_z`, latch g as the job id, set `mul_start`=1, clear the watchdog, set `rr_ptr` = (g+1) mod `NUM_REQ`, go to BUSY.
- **BUSY**
  - `mul_start` is held at 1 and the watchdog increments every cycle.
  - If `mul_done`=1: capture `rsp_y`=`mul_y`, `rsp_err`=0, `rsp_id`=job id; set `mul_start`=0; increment `op_cnt`; go to RESP.
  - Else if the watchdog reaches `TIMEOUT`-1: `rsp_y`=0, `rsp_err`=1, `mul_start`=0, `op_cnt` unchanged, go to RESP.
  - `mul_done` wins if it coincides with the timeout cycle.
- **RESP**
  - `rsp_valid`=1 and `mul_start`=0.
  - `rsp_y`, `rsp_id` and `rsp_err` are stable until the handshake.
  - When `rsp_ready`=1: `rsp_valid` falls at the next edge and the state goes to IDLE.
- Dropping `mul_start` for at least one cycle in RESP clears the multiplier's iteration counter before the next job.
- Requests that arrive in BUSY or RESP stay pending; requesters must hold `req_valid` and their operands until accepted.
- No starvation: with all requesters continuously valid, grants follow 0,1,2,3,0,… for `NUM_REQ`=4.
- Reset
  - Asserted mid-job, it returns to IDLE and drops `mul_start` at the next edge; the in-flight job is discarded with no response.
  - Values: state IDLE, `rr_ptr`=0, `mul_start`=0, `mul_x`=0, `mul_z`=0, `rsp_valid`=0, `rsp_y`=0, `rsp_id`=0, `rsp_err`=0, `busy`=0, `op_cnt`=0.
  - `req_ready` is 0 while `rst_n`=0.

## Timing
- Accept at edge E0, so `mul_start`=1 after E0.
- The multiplier raises `mul_done` after E16.
- Result captured at E17: `rsp_valid`=1 and `mul_start`=0 after E17. Latency from accept to `rsp_valid` is 17 cycles.
- If `rsp_ready` is already high, the handshake occurs at E18 and IDLE is reached after E18. The earliest next accept is E19, giving a minimum of 19 cycles per job.
- `mul_start` is low for at least 2 cycles between jobs.
- Timeout path: with `mul_done` stuck at 0, `rsp_valid`=1 after E`TIMEOUT` (E24 at default) with `rsp_err`=1.
- `rsp_ready` low stalls indefinitely in RESP with outputs stable.

## Test plan
- Single job: requester 2 with x=8'sd5, z=8'sd64, real multiplier, `rsp_ready`=1 -> `req_ready`=4'b0100 for exactly 1 cycle; `rsp_valid` at accept+17 with `rsp_id`=2 and `rsp_err`=0; `rsp_y` equals `mul_y` sampled at `mul_done`; `op_cnt`=1.
- Fairness: all four `req_valid` held high for 8 jobs -> grant order 0,1,2,3,0,1,2,3; each job is 19 cycles apart; `op_cnt`=8.
- Backpressure: `rsp_ready`=0 for 10 cycles after `rsp_valid` -> `rsp_y`, `rsp_id` and `rsp_err` remain constant, `mul_start`=0, no new grant; handshake on the first `rsp_ready`=1.
- Watchdog: multiplier stub with `mul_done` tied to 0 and `mul_y`=16'h1234 -> `rsp_valid` at accept+24 with `rsp_err`=1, `rsp_y`=0; `op_cnt` unchanged; the next job proceeds normally.
- Mid-job reset: `rst_n`=0 for 1 cycle at accept+8 -> `mul_start`=0, `busy`=0, `rr_ptr`=0 and `rsp_valid`=0 after the next edge; no response is issued for the aborted job.
- Counter wrap: preload-free run with a stub that makes `mul_done` rise 1 cycle after start -> `op_cnt` wraps from 16'hFFFF to 16'h0000 after 65536 completions.

Source files
------------

// File: rtl/cordic_mul_arbiter.sv
// Round-robin arbiter and sequencer that shares one CORDIC multiplier among NUM_REQ requesters.
// Drives the multiplier's level-held start/done protocol, returns tagged results, and times out hung jobs.
module cordic_mul_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 24
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_x,
   input  logic [8*NUM_REQ-1:0] req_z,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [15:0]          rsp_y,
   output logic [ID_W-1:0]      rsp_id,
   output logic                 rsp_err,
   output logic                 mul_start,
   output logic [7:0]           mul_x,
   output logic [7:0]           mul_z,
   input  logic                 mul_done,
   input  logic [15:0]          mul_y,
   output logic                 busy,
   output logic [15:0]          op_cnt
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t          state, state_next;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] job_id;
   logic [ID_W-1:0] grant_id;
   logic            grant_any;
   logic [WD_W-1:0] wdog;
   int              idx;

   // Scan downward from the farthest slot so the last hit is the one nearest rr_ptr.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      grant_id  = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (req_valid[idx]) begin
            grant_id  = ID_W'(idx);
            grant_any = 1'b1;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (rst_n && state == IDLE && grant_any)
         req_ready = NUM_REQ'(1) << grant_id;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (grant_any) state_next = BUSY;
         BUSY: if (mul_done || wdog == WD_W'(TIMEOUT - 1)) state_next = RESP;
         RESP: if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         job_id    <= '0;
         wdog      <= '0;
         mul_start <= 1'b0;
         mul_x     <= '0;
         mul_z     <= '0;
         rsp_valid <= 1'b0;
         rsp_y     <= '0;
         rsp_id    <= '0;
         rsp_err   <= 1'b0;
         op_cnt    <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (grant_any) begin
                  mul_x     <= req_x[8*int'(grant_id) +: 8];
                  mul_z     <= req_z[8*int'(grant_id) +: 8];
                  job_id    <= grant_id;
                  mul_start <= 1'b1;
                  wdog      <= '0;
                  rr_ptr    <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
               end
            end
            BUSY: begin
               if (mul_done) begin
                  rsp_y     <= mul_y;
                  rsp_err   <= 1'b0;
                  rsp_id    <= job_id;
                  rsp_valid <= 1'b1;
                  mul_start <= 1'b0;
                  op_cnt    <= op_cnt + 16'd1;
               end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                  rsp_y     <= '0;
                  rsp_err   <= 1'b1;
                  rsp_id    <= job_id;
                  rsp_valid <= 1'b1;
                  mul_start <= 1'b0;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_mul_arbiter.sv
// Directed bench for cordic_mul_arbiter with a behavioural multiplier stub
// whose done latency can be set or stuck low.
module tb_cordic_mul_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_x = '0;
   logic [31:0] req_z = '0;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [15:0] rsp_y;
   logic [1:0]  rsp_id;
   logic        rsp_err;
   logic        mul_start;
   logic [7:0]  mul_x;
   logic [7:0]  mul_z;
   logic        mul_done;
   logic [15:0] mul_y;
   logic        busy;
   logic [15:0] op_cnt;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   cordic_mul_arbiter #(.NUM_REQ(4), .ID_W(2), .TIMEOUT(24)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x), .req_z(req_z),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
      .rsp_id(rsp_id), .rsp_err(rsp_err), .mul_start(mul_start), .mul_x(mul_x),
      .mul_z(mul_z), .mul_done(mul_done), .mul_y(mul_y), .busy(busy), .op_cnt(op_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Multiplier stub: done rises stub_lat cycles after start, held while start stays high.
   int  stub_lat = 16;
   bit  stub_stuck = 1'b0;
   int  stub_cnt = 0;
   logic signed [15:0] prod;
   assign prod     = $signed(mul_x) * $signed(mul_z);
   assign mul_done = !stub_stuck && mul_start && (stub_cnt >= stub_lat);
   assign mul_y    = stub_stuck ? 16'h1234 : prod;
   always @(posedge clk) begin
      if (!mul_start) stub_cnt <= 0;
      else if (stub_cnt < stub_lat) stub_cnt <= stub_cnt + 1;
   end

   // Handshake monitor, sampled mid-cycle ahead of the edge where the transfer happens.
   int          gnt_id_q[$];
   int          gnt_cyc_q[$];
   int          rsp_id_q[$];
   logic [15:0] rsp_y_q[$];
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++)
            if (req_valid[i] && req_ready[i]) begin
               gnt_id_q.push_back(i);
               gnt_cyc_q.push_back(cyc);
            end
         if (rsp_valid && rsp_ready) begin
            rsp_id_q.push_back(int'(rsp_id));
            rsp_y_q.push_back(rsp_y);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_op(input int i, input logic [7:0] x, input logic [7:0] z);
      req_x[8*i +: 8] = x;
      req_z[8*i +: 8] = z;
   endtask

   task automatic do_reset();
      step();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      stub_lat  = 16;
      stub_stuck = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      gnt_id_q.delete();
      gnt_cyc_q.delete();
      rsp_id_q.delete();
      rsp_y_q.delete();
   endtask

   task automatic wait_rsp(input int limit, output int n);
      n = 0;
      while (!rsp_valid && n < limit) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      step();
      rst_n     = 1'b0;
      req_valid = 4'hF;
      step();
      step();
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start: got %b expected 0", mul_start); end
      checks++; if ({mul_x, mul_z} !== 16'h0000) begin errors++; $display("FAIL reset_mul_xz: got %h expected 0000", {mul_x, mul_z}); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      checks++; if ({rsp_y, rsp_id, rsp_err} !== 19'h0) begin errors++; $display("FAIL reset_rsp_fields: got %h expected 0", {rsp_y, rsp_id, rsp_err}); end
      checks++; if (op_cnt !== 16'h0000) begin errors++; $display("FAIL reset_op_cnt: got %h expected 0000", op_cnt); end
      req_valid = '0;
      rst_n = 1'b1;
   endtask

   task automatic test_single_job();
      int n;
      do_reset();
      set_op(2, 8'sd5, 8'sd64);
      req_valid = 4'b0100;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", req_ready); end
      step();
      req_valid = '0;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_grant_drop: got %b expected 0000", req_ready); end
      checks++; if (mul_start !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_start: got start=%b busy=%b expected 1 1", mul_start, busy); end
      checks++; if (mul_x !== 8'd5 || mul_z !== 8'd64) begin errors++; $display("FAIL single_operands: got %h %h expected 05 40", mul_x, mul_z); end
      wait_rsp(40, n);
      checks++; if (n !== 17) begin errors++; $display("FAIL single_latency: got %0d expected 17", n); end
      checks++; if (rsp_y !== 16'd320 || rsp_id !== 2'd2 || rsp_err !== 1'b0) begin errors++; $display("FAIL single_rsp: got y=%h id=%0d err=%b expected 0140 2 0", rsp_y, rsp_id, rsp_err); end
      checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL single_start_low: got %b expected 0", mul_start); end
      step();
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_handshake: got valid=%b busy=%b expected 0 0", rsp_valid, busy); end
      checks++; if (op_cnt !== 16'd1) begin errors++; $display("FAIL single_op_cnt: got %0d expected 1", op_cnt); end
      checks++; if (gnt_id_q.size() !== 1) begin errors++; $display("FAIL single_grant_count: got %0d expected 1", gnt_id_q.size()); end
   endtask

   task automatic test_fairness();
      int n = 0;
      logic [15:0] exp_y[4] = '{16'hFFFE, 16'hFFFA, 16'hFFF4, 16'hFFEC};
      do_reset();
      for (int i = 0; i < 4; i++) set_op(i, 8'(i + 1), 8'(-(i + 2)));
      req_valid = 4'hF;
      while (rsp_id_q.size() < 8 && n < 400) begin
         step();
         n++;
      end
      req_valid = '0;
      step();
      step();
      checks++; if (rsp_id_q.size() !== 8 || gnt_id_q.size() !== 8) begin errors++; $display("FAIL fair_counts: got rsp=%0d gnt=%0d expected 8 8", rsp_id_q.size(), gnt_id_q.size()); end
      checks++; if (op_cnt !== 16'd8) begin errors++; $display("FAIL fair_op_cnt: got %0d expected 8", op_cnt); end
      for (int k = 0; k < 8 && k < gnt_id_q.size() && k < rsp_id_q.size(); k++) begin
         checks++; if (gnt_id_q[k] !== k % 4) begin errors++; $display("FAIL fair_order[%0d]: got %0d expected %0d", k, gnt_id_q[k], k % 4); end
         checks++; if (rsp_id_q[k] !== k % 4 || rsp_y_q[k] !== exp_y[k % 4]) begin errors++; $display("FAIL fair_rsp[%0d]: got id=%0d y=%h expected %0d %h", k, rsp_id_q[k], rsp_y_q[k], k % 4, exp_y[k % 4]); end
         if (k > 0) begin
            checks++; if (gnt_cyc_q[k] - gnt_cyc_q[k-1] !== 19) begin errors++; $display("FAIL fair_spacing[%0d]: got %0d expected 19", k, gnt_cyc_q[k] - gnt_cyc_q[k-1]); end
         end
      end
   endtask

   task automatic test_backpressure();
      int n;
      do_reset();
      rsp_ready = 1'b0;
      set_op(0, -8'sd7, 8'sd9);
      set_op(1, 8'sd2, 8'sd2);
      req_valid = 4'b0001;
      step();
      req_valid = 4'b0010;
      wait_rsp(40, n);
      checks++; if (n !== 17) begin errors++; $display("FAIL bp_latency: got %0d expected 17", n); end
      for (int c = 0; c < 10; c++) begin
         step();
         checks++;
         if (rsp_valid !== 1'b1 || rsp_y !== 16'hFFC1 || rsp_id !== 2'd0 || rsp_err !== 1'b0 ||
             mul_start !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_stall[%0d]: got v=%b y=%h id=%0d err=%b start=%b rdy=%b expected 1 ffc1 0 0 0 0000",
                     c, rsp_valid, rsp_y, rsp_id, rsp_err, mul_start, req_ready);
         end
      end
      rsp_ready = 1'b1;
      step();
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: got valid=%b busy=%b expected 0 0", rsp_valid, busy); end
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_next_grant: got %b expected 0010", req_ready); end
      step();
      req_valid = '0;
      wait_rsp(40, n);
      checks++; if (rsp_id !== 2'd1 || rsp_y !== 16'd4) begin errors++; $display("FAIL bp_second: got id=%0d y=%h expected 1 0004", rsp_id, rsp_y); end
      step();
   endtask

   task automatic test_watchdog();
      int n;
      do_reset();
      stub_stuck = 1'b1;
      set_op(3, 8'sd2, 8'sd3);
      req_valid = 4'b1000;
      step();
      req_valid = '0;
      wait_rsp(60, n);
      checks++; if (n !== 24) begin errors++; $display("FAIL wd_latency: got %0d expected 24", n); end
      checks++; if (rsp_err !== 1'b1 || rsp_y !== 16'h0000 || rsp_id !== 2'd3) begin errors++; $display("FAIL wd_rsp: got err=%b y=%h id=%0d expected 1 0000 3", rsp_err, rsp_y, rsp_id); end
      checks++; if (op_cnt !== 16'd0) begin errors++; $display("FAIL wd_op_cnt: got %0d expected 0", op_cnt); end
      step();
      stub_stuck = 1'b0;
      set_op(0, 8'sd3, 8'sd4);
      req_valid = 4'b0001;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wd_next_grant: got %b expected 0001", req_ready); end
      step();
      req_valid = '0;
      wait_rsp(40, n);
      checks++; if (n !== 17 || rsp_err !== 1'b0 || rsp_y !== 16'd12) begin errors++; $display("FAIL wd_recover: got n=%0d err=%b y=%h expected 17 0 000c", n, rsp_err, rsp_y); end
      step();
      checks++; if (op_cnt !== 16'd1) begin errors++; $display("FAIL wd_recover_cnt: got %0d expected 1", op_cnt); end
   endtask

   task automatic test_mid_reset();
      int n;
      do_reset();
      set_op(1, 8'sd4, 8'sd4);
      set_op(3, 8'sd5, 8'sd5);
      req_valid = 4'b0010;
      step();
      req_valid = '0;
      repeat (7) step();
      rst_n = 1'b0;
      step();
      checks++; if (mul_start !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset: got start=%b busy=%b valid=%b expected 0 0 0", mul_start, busy, rsp_valid); end
      rst_n = 1'b1;
      repeat (20) step();
      checks++; if (rsp_id_q.size() !== 0) begin errors++; $display("FAIL mid_reset_no_rsp: got %0d expected 0", rsp_id_q.size()); end
      req_valid = 4'b1010;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_reset_ptr: got %b expected 0010", req_ready); end
      step();
      req_valid = '0;
      wait_rsp(40, n);
      checks++; if (rsp_id !== 2'd1 || rsp_y !== 16'd16) begin errors++; $display("FAIL mid_reset_job: got id=%0d y=%h expected 1 0010", rsp_id, rsp_y); end
      step();
   endtask

   task automatic test_back_to_back();
      int n = 0;
      do_reset();
      stub_lat = 1;
      set_op(0, 8'sd1, 8'sd1);
      req_valid = 4'b0001;
      while (rsp_id_q.size() < 300 && n < 2000) begin
         step();
         n++;
      end
      req_valid = '0;
      repeat (3) step();
      checks++; if (op_cnt !== 16'd300) begin errors++; $display("FAIL b2b_op_cnt: got %0d expected 300", op_cnt); end
      checks++; if (gnt_cyc_q.size() !== 300) begin errors++; $display("FAIL b2b_grants: got %0d expected 300", gnt_cyc_q.size()); end
      else begin
         checks++; if (gnt_cyc_q[299] - gnt_cyc_q[0] !== 1196) begin errors++; $display("FAIL b2b_rate: got %0d expected 1196", gnt_cyc_q[299] - gnt_cyc_q[0]); end
      end
      stub_lat = 16;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single_job();
      test_fairness();
      test_backpressure();
      test_watchdog();
      test_mid_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
